// File: rtl/secp256k1_mod_pm.sv
// Iterative reducer for pseudo-Mersenne moduli P = 2^W - C: folds the high half by C
// until the value fits in W bits, then performs one conditional subtract of P.
module secp256k1_mod_pm #(
  parameter int unsigned    W        = 256,
  parameter logic [W-1:0]   C        = W'(256'h1000003D1),
  parameter int unsigned    C_BITS   = 33,
  parameter int unsigned    CTL_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [2*W-1:0]      i_dat,
  input  logic [CTL_BITS-1:0] i_ctl,
  input  logic                i_val,
  output logic                o_rdy,
  output logic [W-1:0]        o_dat,
  output logic [CTL_BITS-1:0] o_ctl,
  output logic                o_val,
  input  logic                i_rdy,
  output logic [3:0]          o_folds
);

  if (C_BITS > W - 2) begin : g_bad_c_bits
    $error("secp256k1_mod_pm: C_BITS must not exceed W-2");
  end

  localparam logic [C_BITS-1:0] C_LO = C[C_BITS-1:0];
  localparam logic [W-1:0]      P    = W'(0) - W'(C_LO);

  typedef enum logic [1:0] {S_IDLE, S_FOLD, S_SUB, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2*W-1:0]        x_q, x_d;
  logic [CTL_BITS-1:0]   tag_q, tag_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [W-1:0]          dat_q, dat_d;
  logic                  rdy_q, rdy_d;

  logic [W-1:0]          hi, lo, lo_sub;
  logic [W+C_BITS-1:0]   prod;
  logic [2*W-1:0]        fold_sum;
  logic                  accept, lo_ge_p;

  assign hi       = x_q[2*W-1:W];
  assign lo       = x_q[W-1:0];
  // hi*C + lo stays below 2^(W+C_BITS+1), so the 2W-bit register never overflows.
  assign prod     = {{C_BITS{1'b0}}, hi} * {{W{1'b0}}, C_LO};
  assign fold_sum = {{(W-C_BITS){1'b0}}, prod} + {{W{1'b0}}, lo};
  assign lo_ge_p  = (lo >= P);
  assign lo_sub   = lo - P;
  assign accept   = i_val && rdy_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_FOLD;
      S_FOLD:  if (hi == '0) state_d = S_SUB;
      S_SUB:   state_d = S_DONE;
      S_DONE:  if (i_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d   = x_q;
    tag_d = tag_q;
    cnt_d = cnt_q;
    dat_d = dat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d   = i_dat;
          tag_d = i_ctl;
          cnt_d = '0;
        end
      end
      S_FOLD: begin
        if (hi != '0) begin
          x_d = fold_sum;
          if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
        end
      end
      S_SUB: begin
        // x < 2^W < 2P here, so a single subtract fully reduces.
        if (lo_ge_p) begin
          x_d   = {{W{1'b0}}, lo_sub};
          dat_d = lo_sub;
        end else begin
          dat_d = lo;
        end
      end
      default: ;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      x_q   <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      dat_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
      rdy_q <= rdy_d;
    end
  end

  assign o_rdy   = rdy_q;
  assign o_val   = (state_q == S_DONE);
  assign o_dat   = dat_q;
  assign o_ctl   = tag_q;
  assign o_folds = cnt_q;

endmodule
